// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART transmit path: byte width and the
// request sequencer's state encoding.
package uart_tx_fifo_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT_START = 2'd1,
    S_WAIT_DONE  = 2'd2
  } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo_mem.sv
// DEPTH x DATA_W register array with one synchronous write port and an
// asynchronous read port. Contents are deliberately not reset.
module uart_tx_fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding UART_TX: buffers host writes and hands bytes to the
// transmitter one frame at a time via a req/busy handshake.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DATA_W   = UART_DATA_W,
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int START_TO = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  input  logic              ovf_clr,
  output logic              tx_req,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_busy,
  output logic              start_err
);

  localparam int TIMER_W = (START_TO > 1) ? $clog2(START_TO) : 1;

  tx_state_t           state, state_d;
  logic [TIMER_W-1:0]  timer, timer_d;
  logic [ADDR_W-1:0]   wr_ptr, rd_ptr;
  logic [ADDR_W:0]     count_d;
  logic [DATA_W-1:0]   rd_data, tx_data_d;
  logic                tx_req_d, start_err_d;
  logic                push, pop;

  assign full  = (count == (ADDR_W+1)'(DEPTH));
  assign empty = (count == '0);
  assign push  = wr_en && !full;

  uart_tx_fifo_mem #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk  (clk),
    .we   (push),
    .waddr(wr_ptr),
    .wdata(wr_data),
    .raddr(rd_ptr),
    .rdata(rd_data)
  );

  always_comb begin
    count_d = count;
    if (push && !pop)      count_d = count + (ADDR_W+1)'(1);
    else if (!push && pop) count_d = count - (ADDR_W+1)'(1);
  end

  // A drop in the same cycle as ovf_clr keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      count <= count_d;
      if (wr_en && full) overflow <= 1'b1;
      else if (ovf_clr)  overflow <= 1'b0;
    end
  end

  always_comb begin
    state_d     = state;
    timer_d     = timer;
    tx_req_d    = 1'b0;
    tx_data_d   = tx_data;
    start_err_d = 1'b0;
    pop         = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty && !tx_busy) begin
          pop       = 1'b1;
          tx_data_d = rd_data;
          tx_req_d  = 1'b1;
          timer_d   = '0;
          state_d   = S_WAIT_START;
        end
      end
      S_WAIT_START: begin
        // A byte whose frame never starts is dropped rather than retried.
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
        end else if (timer == TIMER_W'(START_TO - 1)) begin
          start_err_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          timer_d = timer + TIMER_W'(1);
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      timer     <= '0;
      tx_req    <= 1'b0;
      tx_data   <= '0;
      start_err <= 1'b0;
    end else begin
      state     <= state_d;
      timer     <= timer_d;
      tx_req    <= tx_req_d;
      tx_data   <= tx_data_d;
      start_err <= start_err_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_uart_tx_fifo;

  localparam int DEPTH    = 16;
  localparam int START_TO = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full, empty, overflow, ovf_clr;
  logic [4:0] count;
  logic       tx_req, tx_busy, start_err;
  logic [7:0] tx_data;

  int errors = 0;
  int checks = 0;

  uart_tx_fifo #(
    .DATA_W  (8),
    .DEPTH   (DEPTH),
    .ADDR_W  (4),
    .START_TO(START_TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .ovf_clr  (ovf_clr),
    .tx_req   (tx_req),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .start_err(start_err)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: a byte queue plus "phase of the current frame".
  logic [7:0] m_q[$];
  int         m_phase;
  int         m_wait;
  logic       m_ovf, m_req, m_err;
  logic [7:0] m_data;
  logic [7:0] sent[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_phase = 0;
      m_wait  = 0;
      m_ovf   = 1'b0;
      m_req   = 1'b0;
      m_err   = 1'b0;
      m_data  = 8'h00;
    end else begin : model_step
      int pre;
      bit pop_now;
      pre     = m_q.size();
      pop_now = (m_phase == 0) && (pre > 0) && !tx_busy;
      m_req   = 1'b0;
      m_err   = 1'b0;
      if (m_phase == 1) begin
        if (tx_busy) m_phase = 2;
        else begin
          m_wait++;
          if (m_wait == START_TO) begin
            m_err   = 1'b1;
            m_phase = 0;
          end
        end
      end else if (m_phase == 2) begin
        if (!tx_busy) m_phase = 0;
      end
      if (pop_now) begin
        m_data  = m_q.pop_front();
        m_req   = 1'b1;
        m_phase = 1;
        m_wait  = 0;
      end
      if (ovf_clr) m_ovf = 1'b0;
      if (wr_en) begin
        if (pre == DEPTH) m_ovf = 1'b1;
        else m_q.push_back(wr_data);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check_output("cmp_count", 32'(count), 32'(m_q.size()));
      check_output("cmp_empty", 32'(empty), 32'(m_q.size() == 0));
      check_output("cmp_full", 32'(full), 32'(m_q.size() == DEPTH));
      check_output("cmp_overflow", 32'(overflow), 32'(m_ovf));
      check_output("cmp_tx_req", 32'(tx_req), 32'(m_req));
      check_output("cmp_start_err", 32'(start_err), 32'(m_err));
      check_output("cmp_tx_data", 32'(tx_data), 32'(m_data));
      if (tx_req) sent.push_back(tx_data);
    end
  end

  // Transmitter stand-in. mode 0: busy rises 2 cycles after a request and
  // holds 20 cycles; mode 1: busy driven by the main sequence; mode 2: never busy.
  int mode;
  int rise_in = 0;
  int hold    = 0;

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (mode == 0) begin
        if (tx_req) rise_in = 2;
        if (rise_in > 0) begin
          rise_in--;
          if (rise_in == 0) begin
            tx_busy = 1'b1;
            hold    = 20;
          end
        end else if (hold > 0) begin
          hold--;
          if (hold == 0) tx_busy = 1'b0;
        end else begin
          tx_busy = 1'b0;
        end
      end else if (mode == 2) begin
        tx_busy = 1'b0;
        rise_in = 0;
        hold    = 0;
      end else begin
        rise_in = 0;
        hold    = 0;
      end
    end
  end

  task automatic write_byte(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic wait_sent(input int n, input int budget);
    int k;
    k = 0;
    while (sent.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k;
    mode    = 1;
    tx_busy = 1'b0;
    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    ovf_clr = 1'b0;
    repeat (3) @(negedge clk);
    check_output("rst_count", 32'(count), 32'd0);
    check_output("rst_empty", 32'(empty), 32'd1);
    check_output("rst_full", 32'(full), 32'd0);
    check_output("rst_overflow", 32'(overflow), 32'd0);
    check_output("rst_tx_req", 32'(tx_req), 32'd0);
    check_output("rst_tx_data", 32'(tx_data), 32'd0);
    check_output("rst_start_err", 32'(start_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] single byte 0xA5");
    mode = 0;
    sent.delete();
    write_byte(8'hA5);
    check_output("t1_count_after_write", 32'(count), 32'd1);
    k = 0;
    while (!tx_req && k < 10) begin
      @(negedge clk);
      k++;
    end
    check_output("t1_req_latency", 32'(k), 32'd1);
    check_output("t1_tx_data", 32'(tx_data), 32'hA5);
    check_output("t1_count_after_pop", 32'(count), 32'd0);
    check_output("t1_empty_after_pop", 32'(empty), 32'd1);
    repeat (30) @(negedge clk);

    $display("[TB] burst of 16 with transmitter busy, overflow");
    mode    = 1;
    tx_busy = 1'b1;
    sent.delete();
    for (int i = 0; i < 16; i++) write_byte(8'(i));
    check_output("t2_count_full", 32'(count), 32'd16);
    check_output("t2_full", 32'(full), 32'd1);
    write_byte(8'hFF);
    check_output("t2_overflow", 32'(overflow), 32'd1);
    check_output("t2_count_after_drop", 32'(count), 32'd16);
    wr_en   = 1'b1;
    wr_data = 8'hEE;
    ovf_clr = 1'b1;
    @(negedge clk);
    wr_en   = 1'b0;
    ovf_clr = 1'b0;
    check_output("t6_clr_with_drop", 32'(overflow), 32'd1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check_output("t6_clr_alone", 32'(overflow), 32'd0);
    mode = 0;
    wait_sent(16, 1000);
    repeat (30) @(negedge clk);
    check_output("t2_sent_count", 32'(sent.size()), 32'd16);
    for (int i = 0; i < 16 && i < sent.size(); i++)
      check_output($sformatf("t2_order_%0d", i), 32'(sent[i]), 32'(i));

    $display("[TB] simultaneous push/pop and pointer wrap");
    mode    = 1;
    tx_busy = 1'b1;
    sent.delete();
    for (int i = 0; i < 5; i++) write_byte(8'h40 + 8'(i));
    check_output("t3_count_5", 32'(count), 32'd5);
    tx_busy = 1'b0;
    mode    = 0;
    write_byte(8'h45);
    check_output("t3_count_push_pop", 32'(count), 32'd5);
    check_output("t3_req_push_pop", 32'(tx_req), 32'd1);
    check_output("t3_data_push_pop", 32'(tx_data), 32'h40);
    for (int i = 6; i < 40; i++) begin
      k = 0;
      while (m_q.size() >= DEPTH && k < 100) begin
        @(negedge clk);
        k++;
      end
      write_byte(8'h40 + 8'(i));
    end
    wait_sent(40, 2000);
    repeat (30) @(negedge clk);
    check_output("t3_sent_count", 32'(sent.size()), 32'd40);
    for (int i = 0; i < 40 && i < sent.size(); i++)
      check_output($sformatf("t3_order_%0d", i), 32'(sent[i]), 32'h40 + 32'(i));
    check_output("t3_no_overflow", 32'(overflow), 32'd0);

    $display("[TB] start timeout");
    mode = 2;
    sent.delete();
    write_byte(8'h11);
    write_byte(8'h22);
    k = 0;
    while (!tx_req && k < 10) begin
      @(negedge clk);
      k++;
    end
    check_output("t4_first_data", 32'(tx_data), 32'h11);
    k = 0;
    while (!start_err && k < 20) begin
      @(negedge clk);
      k++;
    end
    check_output("t4_start_err_delay", 32'(k), 32'd8);
    check_output("t4_count_at_err", 32'(count), 32'd1);
    @(negedge clk);
    check_output("t4_second_req", 32'(tx_req), 32'd1);
    check_output("t4_second_data", 32'(tx_data), 32'h22);
    check_output("t4_count_lost", 32'(count), 32'd0);
    repeat (12) @(negedge clk);

    $display("[TB] reset during frame");
    mode = 0;
    for (int i = 0; i < 7; i++) write_byte(8'h60 + 8'(i));
    check_output("t5_count_6", 32'(count), 32'd6);
    check_output("t5_busy_mid_frame", 32'(tx_busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_output("t5_rst_count", 32'(count), 32'd0);
    check_output("t5_rst_empty", 32'(empty), 32'd1);
    check_output("t5_rst_tx_req", 32'(tx_req), 32'd0);
    check_output("t5_rst_overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    sent.delete();
    write_byte(8'h5A);
    wait_sent(1, 100);
    check_output("t5_recover_count", 32'(sent.size()), 32'd1);
    if (sent.size() > 0) check_output("t5_recover_data", 32'(sent[0]), 32'h5A);
    repeat (30) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
